// File: rtl/ila_dump_streamer_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the ILA dump streamer.
package ila_dump_streamer_pkg;

   localparam logic [15:0] ILA_DUMP_MAGIC = 16'hA11A;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      WAIT   = 3'd2,
      OUT    = 3'd3,
      FINISH = 3'd4
   } state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Part-select width never collapses to zero, even for single-part samples.
   function automatic int calc_sel_w(input int parts);
      return (parts <= 1) ? 1 : $clog2(parts);
   endfunction

endpackage

// File: rtl/ila_dump_streamer.sv
// Walks the ILA sample buffer after a start command and streams every part-word out on valid/ready.
// Optional header word (magic + sample count) enabled by defining ILA_DUMP_HEADER_EN.
module ila_dump_streamer
   import ila_dump_streamer_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int SIGNAL_W = 64,
   parameter int BUFFER_W = 4,
   parameter int LATENCY  = 2,
   localparam int PARTS   = ceil_div(SIGNAL_W, DATA_W),
   localparam int SEL_W   = calc_sel_w(PARTS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   input  logic                abort,
   input  logic [BUFFER_W-1:0] samples,
   output logic [BUFFER_W-1:0] index,
   output logic [SEL_W-1:0]    value_select,
   input  logic [DATA_W-1:0]   value,
   output logic [DATA_W-1:0]   m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                busy,
   output logic                done
);

   state_t              state_q;
   logic [BUFFER_W-1:0] count_q;
   logic [BUFFER_W-1:0] index_q;
   logic [SEL_W-1:0]    sel_q;
   logic [2:0]          wait_q;
   logic [DATA_W-1:0]   data_q;
   logic                valid_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;

   logic                sel_wrap_d;
   logic [SEL_W-1:0]    sel_d;
   logic [BUFFER_W-1:0] index_d;
   logic                last_d;

   assign sel_wrap_d = (sel_q == SEL_W'(PARTS - 1));
   assign sel_d      = sel_wrap_d ? '0 : sel_q + SEL_W'(1);
   assign index_d    = sel_wrap_d ? index_q + BUFFER_W'(1) : index_q;
   assign last_d     = (index_q == count_q - BUFFER_W'(1)) && sel_wrap_d;

`ifdef ILA_DUMP_HEADER_EN
   logic        hdr_q;
   logic [31:0] hdr_word_d;
   assign hdr_word_d = {ILA_DUMP_MAGIC, 16'(samples)};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         count_q <= '0;
         index_q <= '0;
         sel_q   <= '0;
         wait_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ILA_DUMP_HEADER_EN
         hdr_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         // FINISH already leads to done, so abort there would only add a second pulse.
         if (abort && state_q != IDLE && state_q != FINISH) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= FINISH;
`ifdef ILA_DUMP_HEADER_EN
            hdr_q   <= 1'b0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     count_q <= samples;
                     index_q <= '0;
                     sel_q   <= '0;
                     busy_q  <= 1'b1;
`ifdef ILA_DUMP_HEADER_EN
                     data_q  <= DATA_W'(hdr_word_d);
                     valid_q <= 1'b1;
                     last_q  <= (samples == '0);
                     hdr_q   <= 1'b1;
                     state_q <= OUT;
`else
                     state_q <= (samples == '0) ? FINISH : SETUP;
`endif
                  end
               end
               SETUP: begin
                  wait_q  <= 3'(LATENCY - 1);
                  state_q <= WAIT;
               end
               WAIT: begin
                  if (wait_q == 3'd0) begin
                     data_q  <= value;
                     valid_q <= 1'b1;
                     last_q  <= last_d;
                     state_q <= OUT;
                  end else begin
                     wait_q <= wait_q - 3'd1;
                  end
               end
               OUT: begin
                  if (valid_q && m_ready) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     if (last_q) begin
                        state_q <= FINISH;
`ifdef ILA_DUMP_HEADER_EN
                        hdr_q   <= 1'b0;
                     end else if (hdr_q) begin
                        hdr_q   <= 1'b0;
                        state_q <= SETUP;
`endif
                     end else begin
                        // The final word leaves index on count-1, so the address never wraps.
                        index_q <= index_d;
                        sel_q   <= sel_d;
                        state_q <= SETUP;
                     end
                  end
               end
               FINISH: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign index        = index_q;
   assign value_select = sel_q;
   assign m_data       = data_q;
   assign m_valid      = valid_q;
   assign m_last       = last_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_ila_dump_streamer.sv
// Scoreboard bench for ila_dump_streamer: directed dumps, backpressure, abort, start-while-busy, reset.
module tb_ila_dump_streamer;

   localparam int DATA_W   = 32;
   localparam int SIGNAL_W = 64;
   localparam int BUFFER_W = 4;
   localparam int LATENCY  = 2;
   localparam int PARTS    = 2;
`ifdef ILA_DUMP_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                CLK = 1'b0;
   logic                RST;
   logic                start, abort, m_ready;
   logic [BUFFER_W-1:0] samples;
   logic [BUFFER_W-1:0] index;
   logic [0:0]          value_select;
   logic [DATA_W-1:0]   value;
   logic [DATA_W-1:0]   m_data;
   logic                m_valid, m_last, busy, done;

   always #5 CLK = ~CLK;

   ila_dump_streamer #(
      .DATA_W(DATA_W), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W), .LATENCY(LATENCY)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .samples(samples),
      .index(index), .value_select(value_select), .value(value),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done)
   );

   function automatic logic [31:0] word_of(int idx, int part);
      return 32'hC0DE_0000 | 32'(idx * 16 + part);
   endfunction

   // Buffer model: RAM read register then value register, two cycles of latency.
   logic [31:0] pipe1;
   always @(posedge CLK) begin
      pipe1 <= word_of(int'(index), int'(value_select));
      value <= pipe1;
   end

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   vecs = 0;
   int   errs = 0;
   int   words_seen = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   last_pending = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      vecs++;
      errs++;
      $display("FAIL %s: timed out", name);
   endtask

   // Monitor: pops and compares on every handshake; also times done against the final word.
   always @(negedge CLK) begin
      if (!RST && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_word");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("word %0d: data=%h last=%b index=%0d", words_seen, m_data, m_last, index);
            check("word_data", m_data, e.data);
            check("word_last", 32'(m_last), 32'(e.last));
         end
         words_seen++;
         if (m_last) begin
            last_pending = 1;
            last_cyc = cyc;
         end
      end
      if (!RST && done) begin
         done_cnt++;
         if (last_pending) begin
            check("done_gap", 32'(cyc - last_cyc), 32'd2);
            last_pending = 0;
         end
      end
   end

   task automatic push_dump(int n);
`ifdef ILA_DUMP_HEADER_EN
      exp_q.push_back('{32'hA11A_0000 | 32'(n), n == 0});
`endif
      for (int i = 0; i < n; i++)
         for (int p = 0; p < PARTS; p++)
            exp_q.push_back('{word_of(i, p), (i == n - 1) && (p == PARTS - 1)});
   endtask

   task automatic pulse_start(int n);
      samples = BUFFER_W'(n);
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(int budget, string name);
      int n = 0;
      @(negedge CLK);
      while (!done && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (!done) timeout(name);
      check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_words(int target, string name);
      int n = 0;
      while (words_seen < target && n < 400) begin
         @(posedge CLK);
         n++;
      end
      if (words_seen < target) timeout(name);
   endtask

   task automatic wait_valid(string name);
      int n = 0;
      @(negedge CLK);
      while (!m_valid && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!m_valid) timeout(name);
   endtask

   initial begin
      int base, dcnt, vcnt;
      logic [31:0] held;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, dcnt, vcnt;
      RST = 1'b1; start = 1'b0; abort = 1'b0; samples = '0; m_ready = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_index", 32'(index), 32'd0);
      check("rst_sel", 32'(value_select), 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_ctrl", {28'd0, m_valid, m_last, busy, done}, 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;

      // Abort while idle is ignored.
      dcnt = done_cnt;
      abort = 1'b1;
      @(posedge CLK);
      #1 abort = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("idle_abort_done", 32'(done_cnt - dcnt), 32'd0);

      // Basic dump of three samples.
      base = words_seen;
      dcnt = done_cnt;
      push_dump(3);
      pulse_start(3);
      wait_done(100, "basic");
      check("basic_words", 32'(words_seen - base), 32'(6 + HDR));
      check("basic_done_once", 32'(done_cnt - dcnt), 32'd1);
      check("basic_index", 32'(index), 32'd2);

      // Empty buffer.
      base = words_seen;
      push_dump(0);
      pulse_start(0);
`ifdef ILA_DUMP_HEADER_EN
      wait_done(20, "empty");
      check("empty_words", 32'(words_seen - base), 32'd1);
`else
      @(negedge CLK);
      check("empty_busy_c1", {30'd0, busy, done}, 32'b10);
      @(negedge CLK);
      check("empty_done_c2", {30'd0, busy, done}, 32'b01);
      check("empty_words", 32'(words_seen - base), 32'd0);
      @(posedge CLK);
      #1;
`endif

      // Backpressure on the third data word (sample 1, part 0).
      base = words_seen;
      push_dump(3);
      pulse_start(3);
      wait_words(base + 2 + HDR, "bp_words");
      #1 m_ready = 1'b0;
      wait_valid("bp_valid");
      for (int k = 0; k < 5; k++) begin
         check("bp_valid_hold", 32'(m_valid), 32'd1);
         check("bp_data_hold", m_data, word_of(1, 0));
         check("bp_last_hold", 32'(m_last), 32'd0);
         check("bp_index_hold", 32'(index), 32'd1);
         @(negedge CLK);
      end
      @(posedge CLK);
      #1 m_ready = 1'b1;
      wait_done(100, "bp");
      check("bp_words_total", 32'(words_seen - base), 32'(6 + HDR));

      // Full buffer: 15 samples, highest address 14.
      base = words_seen;
      push_dump(15);
      pulse_start(15);
      wait_done(400, "full");
      check("full_words", 32'(words_seen - base), 32'(30 + HDR));
      check("full_index", 32'(index), 32'd14);

      // Abort during WAIT of the third data word, then restart with start+abort together.
      base = words_seen;
      dcnt = done_cnt;
      push_dump(4);
      pulse_start(4);
      wait_words(base + 2 + HDR, "abort_words");
      #1;
      @(posedge CLK);
      #1 abort = 1'b1;
      @(posedge CLK);
      #1 abort = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (m_valid) vcnt++;
      end
      check("abort_no_valid", 32'(vcnt), 32'd0);
      check("abort_done_once", 32'(done_cnt - dcnt), 32'd1);
      check("abort_words", 32'(words_seen - base), 32'(2 + HDR));
      exp_q.delete();
      @(posedge CLK);
      #1;
      base = words_seen;
      push_dump(2);
      abort = 1'b1;
      pulse_start(2);
      abort = 1'b0;
      wait_done(100, "restart");
      check("restart_words", 32'(words_seen - base), 32'(4 + HDR));

      // Extra starts while busy, with samples changing, are ignored.
      base = words_seen;
      dcnt = done_cnt;
      push_dump(2);
      pulse_start(2);
      samples = 4'd5;
      for (int k = 0; k < 3; k++) begin
         repeat (2) @(posedge CLK);
         #1 start = 1'b1;
         @(posedge CLK);
         #1 start = 1'b0;
      end
      wait_done(100, "busy_start");
      repeat (4) @(posedge CLK);
      #1;
      check("busy_start_words", 32'(words_seen - base), 32'(4 + HDR));
      check("busy_start_done", 32'(done_cnt - dcnt), 32'd1);
      check("busy_start_idle", 32'(busy), 32'd0);

      // Reset asserted mid-OUT clears everything without a done pulse.
      base = words_seen;
      push_dump(3);
      pulse_start(3);
      wait_words(base + 3 + HDR, "rst_words");
      #1 m_ready = 1'b0;
      wait_valid("rst_valid");
      dcnt = done_cnt;
      #2 RST = 1'b1;
      #1;
      check("midrst_index", 32'(index), 32'd0);
      check("midrst_sel", 32'(value_select), 32'd0);
      check("midrst_data", m_data, 32'd0);
      check("midrst_ctrl", {28'd0, m_valid, m_last, busy, done}, 32'd0);
      exp_q.delete();
      last_pending = 0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      m_ready = 1'b1;
      repeat (4) @(negedge CLK);
      check("midrst_no_done", 32'(done_cnt - dcnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
